signed_extrema_ctrl: RTL and testbench



---
 rtl/signed_extrema_pkg.sv | 17 +
 rtl/signed_gt_cmp.sv | 21 ++
 rtl/signed_extrema_ctrl.sv | 140 ++++++++++++++
 tb/tb_signed_extrema_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/signed_extrema_pkg.sv
// Shared definitions for the signed extrema controller: FSM state encoding
// and default sample/index widths.
// Latency: n/a (definitions only). Backpressure: n/a.
package signed_extrema_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    // IDLE waits for the first sample, ACC folds in the rest of the frame,
    // HOLD presents the result and blocks input until it is taken.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/signed_gt_cmp.sv
// Combinational signed greater-than: o_gt = (i_a > i_b) for two's complement.
// Latency: 0 cycles (pure combinational). Backpressure: n/a.
// Ports: i_a, i_b (WIDTH-bit signed operands), o_gt (1 when i_a > i_b).
module signed_gt_cmp #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_gt
);

    // Flipping the sign bit maps two's complement onto offset binary, so an
    // unsigned compare of the flipped values orders the signed values.
    logic [WIDTH-1:0] w_a_off;
    logic [WIDTH-1:0] w_b_off;

    assign w_a_off = {~i_a[WIDTH-1], i_a[WIDTH-2:0]};
    assign w_b_off = {~i_b[WIDTH-1], i_b[WIDTH-2:0]};
    assign o_gt    = (w_a_off > w_b_off);

endmodule

// File: rtl/signed_extrema_ctrl.sv
// Per-frame running signed max/min with first-occurrence indices and count.
// Latency: res_valid rises the cycle after the frame's closing sample transfer.
// Backpressure: in_ready drops only while a result is held; res_* hold until res_ready.
// Ports: sys_clk/sys_rst (sync, active-high); in_valid/in_ready/in_data/in_last
//        sample stream; res_valid/res_ready handshake with res_max, res_min,
//        res_max_idx, res_min_idx, res_count, res_trunc; busy = mid-frame.
module signed_extrema_ctrl
    import signed_extrema_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_max,
    output logic [WIDTH-1:0] res_min,
    output logic [CNT_W-1:0] res_max_idx,
    output logic [CNT_W-1:0] res_min_idx,
    output logic [CNT_W:0]   res_count,
    output logic             res_trunc,
    output logic             busy
);

    localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_min;
    logic [CNT_W-1:0] r_max_idx;
    logic [CNT_W-1:0] r_min_idx;
    logic [CNT_W:0]   r_count;
    logic             r_trunc;
    logic             r_res_valid;
    logic             r_busy;

    logic             w_max_upd;
    logic             w_min_upd;
    logic             w_at_limit;

    // Max path: new sample strictly above the current max.
    signed_gt_cmp #(.WIDTH(WIDTH)) u_cmp_max (
        .i_a  (in_data),
        .i_b  (r_max),
        .o_gt (w_max_upd)
    );

    // Min path: operands swapped, current min strictly above the new sample.
    signed_gt_cmp #(.WIDTH(WIDTH)) u_cmp_min (
        .i_a  (r_min),
        .i_b  (in_data),
        .o_gt (w_min_upd)
    );

    // In ACC the count never exceeds 2^CNT_W-1, so the low bits are the index
    // of the incoming sample; all-ones means this is the last slot available.
    assign w_at_limit = (r_count[CNT_W-1:0] == {CNT_W{1'b1}});

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_max       <= '0;
            r_min       <= '0;
            r_max_idx   <= '0;
            r_min_idx   <= '0;
            r_count     <= '0;
            r_trunc     <= 1'b0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_max     <= in_data;
                        r_min     <= in_data;
                        r_max_idx <= '0;
                        r_min_idx <= '0;
                        r_count   <= CNT_ONE;
                        r_trunc   <= 1'b0;
                        if (in_last) begin
                            r_state     <= HOLD;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state <= ACC;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        // Strict compares: ties keep the earlier index.
                        if (w_max_upd) begin
                            r_max     <= in_data;
                            r_max_idx <= r_count[CNT_W-1:0];
                        end
                        if (w_min_upd) begin
                            r_min     <= in_data;
                            r_min_idx <= r_count[CNT_W-1:0];
                        end
                        r_count <= r_count + CNT_ONE;
                        if (in_last || w_at_limit) begin
                            r_state     <= HOLD;
                            r_res_valid <= 1'b1;
                            r_busy      <= 1'b0;
                            r_trunc     <= w_at_limit && !in_last;
                        end
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    // r_res_valid is high exactly in HOLD, so it doubles as the input stall.
    assign in_ready    = ~r_res_valid;
    assign res_valid   = r_res_valid;
    assign busy        = r_busy;
    assign res_max     = r_max;
    assign res_min     = r_min;
    assign res_max_idx = r_max_idx;
    assign res_min_idx = r_min_idx;
    assign res_count   = r_count;
    assign res_trunc   = r_trunc;

endmodule

// File: tb/tb_signed_extrema_ctrl.sv
module tb_signed_extrema_ctrl;

    localparam int W  = 8;
    localparam int CW = 4;
    localparam int MAXLEN = 1 << CW;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_max;
    logic [W-1:0]  res_min;
    logic [CW-1:0] res_max_idx;
    logic [CW-1:0] res_min_idx;
    logic [CW:0]   res_count;
    logic          res_trunc;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    always #5 sys_clk = ~sys_clk;

    signed_extrema_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_max     (res_max),
        .res_min     (res_min),
        .res_max_idx (res_max_idx),
        .res_min_idx (res_min_idx),
        .res_count   (res_count),
        .res_trunc   (res_trunc),
        .busy        (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Collects the frame's samples; when the frame closes, scans the list
    // with plain signed integer compares to produce the expected result.
    logic [W-1:0] m_q[$];
    bit           m_have = 1'b0;
    int           m_max, m_min, m_max_idx, m_min_idx, m_count;
    bit           m_trunc;

    task automatic model_close(input bit last);
        int v;
        m_max = $signed(m_q[0]); m_min = m_max;
        m_max_idx = 0; m_min_idx = 0;
        for (int i = 1; i < m_q.size(); i++) begin
            v = $signed(m_q[i]);
            if (v > m_max) begin m_max = v; m_max_idx = i; end
            if (v < m_min) begin m_min = v; m_min_idx = i; end
        end
        m_count = m_q.size();
        m_trunc = !last;
        m_have  = 1'b1;
        m_q.delete();
    endtask

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_q.delete();
            m_have = 1'b0;
        end else if (m_have) begin
            if (res_ready) m_have = 1'b0;
        end else if (in_valid) begin
            m_q.push_back(in_data);
            if (in_last || m_q.size() == MAXLEN) model_close(in_last);
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("m_res_valid", {31'd0, res_valid}, {31'd0, m_have});
            check("m_in_ready", {31'd0, in_ready}, {31'd0, !m_have});
            check("m_busy", {31'd0, busy}, {31'd0, (m_q.size() > 0) && !m_have});
            if (m_have) begin
                check("m_res_max", {24'd0, res_max}, 32'(m_max) & 32'hFF);
                check("m_res_min", {24'd0, res_min}, 32'(m_min) & 32'hFF);
                check("m_max_idx", {28'd0, res_max_idx}, 32'(m_max_idx));
                check("m_min_idx", {28'd0, res_min_idx}, 32'(m_min_idx));
                check("m_count", {27'd0, res_count}, 32'(m_count));
                check("m_trunc", {31'd0, res_trunc}, {31'd0, m_trunc});
            end
        end
    end

    // ---------------- stimulus ----------------
    // All tasks are entered and return at a falling edge.
    task automatic send(input logic [W-1:0] d, input bit last);
        in_valid = 1'b1; in_data = d; in_last = last;
        @(negedge sys_clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic drain(input int stall);
        int t = 0;
        while (!res_valid && t < 20) begin @(negedge sys_clk); t++; end
        if (!res_valid) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: res_valid got 0 expected 1");
        end
        repeat (stall) @(negedge sys_clk);
        res_ready = 1'b1;
        @(negedge sys_clk);
        res_ready = 1'b0;
    endtask

    task automatic expect_res(input string tag, input logic [W-1:0] mx, input int mxi,
                              input logic [W-1:0] mn, input int mni, input int cnt, input bit tr);
        check({tag, "_valid"}, {31'd0, res_valid}, 32'd1);
        check({tag, "_max"}, {24'd0, res_max}, {24'd0, mx});
        check({tag, "_max_idx"}, {28'd0, res_max_idx}, 32'(mxi));
        check({tag, "_min"}, {24'd0, res_min}, {24'd0, mn});
        check({tag, "_min_idx"}, {28'd0, res_min_idx}, 32'(mni));
        check({tag, "_count"}, {27'd0, res_count}, 32'(cnt));
        check({tag, "_trunc"}, {31'd0, res_trunc}, {31'd0, tr});
    endtask

    logic [W-1:0] s_max, s_min;
    logic [CW:0]  s_cnt;

    initial begin
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        chk_en  = 1'b1;

        // reset state
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_max", {24'd0, res_max}, 32'd0);
        check("rst_min", {24'd0, res_min}, 32'd0);
        check("rst_count", {27'd0, res_count}, 32'd0);
        check("rst_trunc", {31'd0, res_trunc}, 32'd0);

        // mixed-sign frame; result must be valid at the edge after the last transfer
        send(8'h05, 0);
        check("f1_busy", {31'd0, busy}, 32'd1);
        send(8'hFB, 0); send(8'h7F, 0); send(8'h80, 0); send(8'h00, 1);
        expect_res("f1", 8'h7F, 2, 8'h80, 3, 5, 0);
        drain(0);

        // ties: first occurrence wins
        send(8'h03, 0); send(8'h03, 0); send(8'hFD, 0); send(8'hFD, 1);
        expect_res("tie", 8'h03, 0, 8'hFD, 2, 4, 0);
        drain(0);

        // single-sample frame
        send(8'h81, 1);
        expect_res("one", 8'h81, 0, 8'h81, 0, 1, 0);
        drain(0);

        // length limit closes the frame
        for (int i = 0; i < MAXLEN; i++) send(W'(i), 0);
        expect_res("lim", 8'h0F, 15, 8'h00, 0, 16, 1);
        check("lim_in_ready", {31'd0, in_ready}, 32'd0);
        // a sample offered while holding must be ignored
        in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
        repeat (3) @(negedge sys_clk);
        in_valid = 1'b0; in_last = 1'b0;
        check("lim_hold_max", {24'd0, res_max}, 32'h0F);
        drain(0);

        // long stall: result stable, input blocked, then next frame right after
        send(8'h01, 0); send(8'hFE, 1);
        s_max = res_max; s_min = res_min; s_cnt = res_count;
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_max", {24'd0, res_max}, {24'd0, s_max});
            check("stall_min", {24'd0, res_min}, {24'd0, s_min});
            check("stall_count", {27'd0, res_count}, {27'd0, s_cnt});
            @(negedge sys_clk);
        end
        expect_res("stall", 8'h01, 0, 8'hFE, 1, 2, 0);
        res_ready = 1'b1;
        @(negedge sys_clk);
        res_ready = 1'b0;
        check("post_valid", {31'd0, res_valid}, 32'd0);
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
        send(8'h07, 1);
        expect_res("post", 8'h07, 0, 8'h07, 0, 1, 0);
        drain(0);

        // reset mid-frame discards the partial frame
        send(8'h20, 0); send(8'h30, 0); send(8'hC0, 0);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("mrst_valid", {31'd0, res_valid}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_count", {27'd0, res_count}, 32'd0);
        send(8'h10, 0); send(8'hF0, 1);
        expect_res("mrst", 8'h10, 0, 8'hF0, 1, 2, 0);
        drain(2);

        repeat (3) @(negedge sys_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
